traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
- Single-intersection traffic-light controller: a free-running Moore state machine that cycles RED -> GREEN -> YELLOW -> RED.
- Drives a 3-bit one-hot lamp vector.
- Each phase lasts a parameterizable number of clock cycles.
- Leaf block: no inputs other than clock and reset; its output feeds lamp drivers or display logic.

Parameters:
- RED_CYCLES, 1, cycles the RED phase is held (legal range 1..65535)
- GREEN_CYCLES, 1, cycles the GREEN phase is held (legal range 1..65535)
- YELLOW_CYCLES, 1, cycles the YELLOW phase is held (legal range 1..65535)

Ports:
- clock  input  1  rising-edge system clock
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clock
- light  output  3  one-hot lamp vector: bit2 = red, bit1 = yellow, bit0 = green

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are named clock and reset_n.
- States and encodings (light is a pure function of state, registered, no combinational glitching):
  - RED drives 3'b100
  - GREEN drives 3'b001
  - YELLOW drives 3'b010
- Reset: while reset_n=0 at a rising edge, the next state is RED, the dwell counter is 0, and light=3'b100 from that edge onward. Reset overrides any pending transition, including mid-phase.
- Dwell counter:
  - Width is ceil(log2(max(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES))), minimum 1 bit.
  - Counts edges spent in the current phase.
  - When the count equals (phase_CYCLES - 1), the next edge advances the state and clears the counter to 0. Otherwise the counter increments.
- Transitions (unconditional): RED -> GREEN, GREEN -> YELLOW, YELLOW -> RED.
- Timing: after reset release, light stays 3'b100 for exactly RED_CYCLES edges, then 3'b001 for GREEN_CYCLES edges, then 3'b010 for YELLOW_CYCLES edges, then repeats. Period is RED_CYCLES + GREEN_CYCLES + YELLOW_CYCLES.
- With all parameters = 1, light changes on every rising edge: 100, 001, 010, 100, ...
- Illegal or unreachable state encodings recover to RED with counter 0 on the next edge.
- Before the first reset, light is undefined; the bench must apply reset.
- Invariant: exactly one bit of light is set at all times after reset.
- Parameter values of 0 are rejected at elaboration (elaboration-time error).

Decomposition:
- Package traffic_light_pkg holds:
  - the state enum (RED, GREEN, YELLOW, 2-bit encoding)
  - the lamp encoding constants LIGHT_RED = 3'b100, LIGHT_GREEN = 3'b001, LIGHT_YELLOW = 3'b010
- Optional sub-module phase_timer: a loadable down/up counter with a terminal-count output. The FSM selects its limit per state.

Test Plan:
- Defaults (1,1,1), reset_n low 2 cycles then high:
  - light = 100 during reset
  - then per edge: 001, 010, 100, 001 …
  - period 3 cycles, checked over 10 cycles.
- RED=4, GREEN=3, YELLOW=2, reset then run 20 cycles:
  - light pattern 100×4, 001×3, 010×2, repeating, period 9.
- Mid-phase reset: during GREEN with counter at 1 (RED=4, GREEN=3), pull reset_n low for 1 edge:
  - light = 100 on that edge
  - RED then holds the full 4 cycles after release.
- Reset asserted without a clock edge:
  - light unchanged until the next rising edge (confirms synchronous reset).
- One-hot assertion: over 200 random-length runs with random mid-run resets:
  - $onehot(light) always true after the first reset
  - no transition ever skips a state (100 is only ever followed by 001, 001 by 010, 010 by 100).

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared types and lamp encodings for the traffic-light controller.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_e;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;

  // Lamp vector shown for a given state; unknown encodings show red.
  function automatic logic [2:0] light_of(state_e s);
    case (s)
      RED:     light_of = LIGHT_RED;
      GREEN:   light_of = LIGHT_GREEN;
      YELLOW:  light_of = LIGHT_YELLOW;
      default: light_of = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Phase dwell counter: counts edges in the current phase and flags the last one.
// Ports:
//   clock   - rising-edge clock
//   reset_n - synchronous active-low reset, clears the count
//   limit   - terminal count for the current phase (phase cycles - 1)
//   done_c  - combinational: this edge ends the phase; the count wraps to 0
module traffic_light_ctrl_phase_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] limit,
  output logic             done_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // >= rather than == so a count stranded above a new limit still wraps.
  always_comb begin
    done_c  = (count_q >= limit);
    count_d = done_c ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Free-running RED -> GREEN -> YELLOW traffic-light Moore FSM with per-phase dwell.
// Ports:
//   clock   - rising-edge clock
//   reset_n - synchronous active-low reset; forces RED with the dwell count cleared
//   light   - registered one-hot lamps: bit2 red, bit1 yellow, bit0 green
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_CYCLES    = 1,
  parameter int unsigned GREEN_CYCLES  = 1,
  parameter int unsigned YELLOW_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [2:0] light
);

  localparam int unsigned MAX_RG     = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_RG > YELLOW_CYCLES) ? MAX_RG : YELLOW_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  if (RED_CYCLES == 0 || GREEN_CYCLES == 0 || YELLOW_CYCLES == 0) begin : g_bad_cycles
    $error("traffic_light_ctrl: phase cycle counts must be nonzero");
  end

  state_e           state_q;
  state_e           state_d;
  logic [2:0]       light_q;
  logic [2:0]       light_d;
  logic [CNT_W-1:0] limit_c;
  logic             done_c;

  traffic_light_ctrl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .limit   (limit_c),
    .done_c  (done_c)
  );

  // Next state and phase limit. An illegal state gets limit 0, so the timer
  // wraps to 0 on the same edge the state recovers to RED.
  always_comb begin
    state_d = RED;
    limit_c = '0;
    case (state_q)
      RED: begin
        limit_c = CNT_W'(RED_CYCLES - 1);
        state_d = done_c ? GREEN : RED;
      end
      GREEN: begin
        limit_c = CNT_W'(GREEN_CYCLES - 1);
        state_d = done_c ? YELLOW : GREEN;
      end
      YELLOW: begin
        limit_c = CNT_W'(YELLOW_CYCLES - 1);
        state_d = done_c ? RED : YELLOW;
      end
      default: begin
        state_d = RED;
        limit_c = '0;
      end
    endcase
    light_d = light_of(state_d);
  end

  // Lamps are registered from the next state so they change with the state flop.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= RED;
      light_q <= LIGHT_RED;
    end else begin
      state_q <= state_d;
      light_q <= light_d;
    end
  end

  assign light = light_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed and randomized checks of traffic_light_ctrl timing, reset and one-hot lamps.
module tb_traffic_light_ctrl;

  logic       clock;
  logic       rst_a_n;
  logic       rst_b_n;
  logic [2:0] light_a;
  logic [2:0] light_b;

  int total;
  int bad;

  // Instance A uses the default 1/1/1 timing; instance B uses 4/3/2.
  traffic_light_ctrl u_dut_a (
    .clock   (clock),
    .reset_n (rst_a_n),
    .light   (light_a)
  );

  traffic_light_ctrl #(
    .RED_CYCLES    (4),
    .GREEN_CYCLES  (3),
    .YELLOW_CYCLES (2)
  ) u_dut_b (
    .clock   (clock),
    .reset_n (rst_b_n),
    .light   (light_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sample index 0 is the last reset edge; index n is n edges after release.
  logic [2:0] pat_a [3] = '{3'b100, 3'b001, 3'b010};
  logic [2:0] pat_b [9] = '{3'b100, 3'b100, 3'b100, 3'b100,
                            3'b001, 3'b001, 3'b001, 3'b010, 3'b010};

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] succ(input logic [2:0] l);
    case (l)
      3'b100:  succ = 3'b001;
      3'b001:  succ = 3'b010;
      3'b010:  succ = 3'b100;
      default: succ = 3'bxxx;
    endcase
  endfunction

  initial begin
    int         idx;
    int         len;
    logic [2:0] prev;

    total   = 0;
    bad     = 0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;

    // Defaults: reset two edges, then 10 cycles of period 3.
    tick();
    tick();
    chk("rst_a", light_a, 3'b100);
    chk("rst_b", light_b, 3'b100);
    rst_a_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("dflt", light_a, pat_a[i % 3]);
    end

    // 4/3/2 timing over 20 cycles, period 9.
    rst_b_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("p432", light_b, pat_b[i % 9]);
    end

    // Re-sync, run to GREEN with count 1, then reset for one edge.
    rst_b_n = 1'b0;
    tick();
    rst_b_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("pre_mid", light_b, pat_b[i]);
    end
    rst_b_n = 1'b0;
    tick();
    chk("mid_rst", light_b, 3'b100);
    rst_b_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("post_mid", light_b, pat_b[i]);
    end

    // Reset raised between edges must not change the lamps until the next edge.
    rst_b_n = 1'b0;
    #3;
    chk("no_edge", light_b, 3'b001);
    tick();
    chk("edge_rst", light_b, 3'b100);

    // Random run lengths with random reset pulses.
    idx  = 0;
    prev = light_b;
    for (int r = 0; r < 200; r++) begin
      if ($urandom_range(0, 3) != 0) begin
        rst_b_n = 1'b0;
        len = $urandom_range(1, 2);
        for (int k = 0; k < len; k++) begin
          tick();
          chk("rnd_rst", light_b, 3'b100);
        end
        idx  = 0;
        prev = light_b;
      end
      rst_b_n = 1'b1;
      len = $urandom_range(1, 30);
      for (int k = 0; k < len; k++) begin
        tick();
        idx++;
        chk("rnd_model", light_b, pat_b[idx % 9]);
        chk("onehot", {2'b00, $onehot(light_b)}, 3'b001);
        if (light_b !== prev) begin
          chk("seq", light_b, succ(prev));
        end
        prev = light_b;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
